normalize_shifter: RTL
======================

NORMALIZE_SHIFTER -- requirements
Module: normalize_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, mantissa datapath width.
REQ-002 SHALL have parameter REF, default 28, target bit position of the leading one (0 <= REF < WIDTH).
REQ-003 SHALL have parameter EXP_W, default 11, exponent width (unsigned).
REQ-004 SHALL have parameter DIST_W, default 8, signed distance width; must hold ±(WIDTH-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operand offered.
REQ-008 in_ready  output  1  block can accept an operand.
REQ-009 mant_in  input  WIDTH  unnormalized mantissa.
REQ-010 exp_in  input  EXP_W  exponent paired with mant_in.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 mant_out  output  WIDTH  mantissa with leading one at bit REF.
REQ-014 exp_out  output  EXP_W  exponent adjusted by distance, saturated.
REQ-015 distance  output  DIST_W  signed (leading-one position - REF).
REQ-016 sticky  output  1  OR of all bits shifted out below bit 0.
REQ-017 zero  output  1  mant_in was all zeros.
REQ-018 exp_uflow / exp_oflow  output  1 each  exponent saturation flags.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, SHIFT, DONE.
REQ-020 IDLE: in_ready=1; on in_valid&in_ready, register mant_in and exp_in, clear sticky, go to SCAN.
REQ-021 SCAN: leading-one detect on registered mantissa; store distance and remaining=|distance|; next state DONE if mantissa zero or distance=0, else SHIFT.
REQ-022 SHIFT: one-bit shift per cycle; right if distance>0 (bit 0 ORed into sticky), left if distance<0 (zero fill); remaining decrements; go to DONE when remaining reaches 0 on that edge.
REQ-023 Latency: out_valid SHALL rise exactly 2+|distance| clock edges after the accept edge.
REQ-024 exp_out SHALL be computed in EXP_W+2-bit signed arithmetic as exp_in+distance; result <0 gives exp_out=0 and exp_uflow=1; result >2^EXP_W-1 gives exp_out=all ones and exp_oflow=1.
REQ-025 Zero mantissa: zero=1, distance=0, mant_out=0, exp_out=0, sticky=0, no flags.
REQ-026 DONE: out_valid=1; all outputs held stable while out_ready=0; on out_valid&out_ready go to IDLE.
REQ-027 in_ready SHALL be 0 in SCAN, SHIFT, DONE; in_valid ignored there (no queuing).
REQ-028 Outputs SHALL be registered; meaningful only while out_valid=1, retained until next accept.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, all data outputs and flags 0, distance=0.
REQ-030 Reset asserted mid-SCAN/SHIFT/DONE SHALL abort the operation with no result delivered; first post-reset accept behaves as from power-up.

Verification
REQ-031 mant_in=0x0000_0008_1000_0000, exp_in=1023 -> distance=+7, mant_out=0x0000_0000_1020_0000, exp_out=1030, sticky=0, out_valid 9 edges after accept.
REQ-032 mant_in=0x0000_0000_0080_0000, exp_in=1023 -> distance=-5 (0xFB), mant_out=0x0000_0000_1000_0000, exp_out=1018, out_valid 7 edges after accept.
REQ-033 mant_in=0x0000_0000_1FF0_0000 -> distance=0, mant_out unchanged, out_valid 2 edges after; mant_in=0 -> zero=1, all else 0, out_valid 2 edges after.
REQ-034 mant_in=0x0000_0008_0000_0001 -> distance=+7, mant_out=0x0000_0000_1000_0000, sticky=1.
REQ-035 mant_in=0x0000_0000_0080_0000, exp_in=3 -> exp_out=0, exp_uflow=1; mant_in bit 63 set, exp_in=2040 -> exp_out=2047, exp_oflow=1.
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; rst_n pulsed low during SHIFT -> out_valid never asserts, in_ready=1 immediately.

Source files
------------

// File: rtl/normalize_shifter.sv
// Floating-point mantissa normalizer: moves the leading one to bit REF with a
// one-bit-per-cycle shifter, adjusts and saturates the exponent, tracks sticky.
module normalize_shifter #(
  parameter int WIDTH  = 64,
  parameter int REF    = 28,
  parameter int EXP_W  = 11,
  parameter int DIST_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         mant_in,
  input  logic [EXP_W-1:0]         exp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         mant_out,
  output logic [EXP_W-1:0]         exp_out,
  output logic signed [DIST_W-1:0] distance,
  output logic                     sticky,
  output logic                     zero,
  output logic                     exp_uflow,
  output logic                     exp_oflow,
  output logic [1:0]               state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and the result fields stay frozen until that edge.

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                    state;
  state_t                    next_state;
  logic [WIDTH-1:0]          mant_r;
  logic [EXP_W-1:0]          exp_r;
  logic                      sticky_r;
  logic                      zero_r;
  logic signed [DIST_W-1:0]  dist_r;
  logic [DIST_W-1:0]         remaining;
  logic [POS_W-1:0]          lead_pos;
  logic signed [DIST_W-1:0]  dist_calc;
  logic [DIST_W-1:0]         dist_mag;
  logic                      mant_is_zero;
  logic signed [EXP_W+1:0]   exp_sum;
  logic                      accept;
  logic                      fire;
  logic                      load_result;

  // Leading-one detector: the highest set bit wins.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mant_r[i]) lead_pos = POS_W'(i);
    end
  end

  assign mant_is_zero = ~|mant_r;
  assign dist_calc    = DIST_W'(lead_pos) - DIST_W'(REF);
  assign dist_mag     = dist_calc[DIST_W-1] ? DIST_W'(-dist_calc) : DIST_W'(dist_calc);
  assign exp_sum      = $signed({2'b00, exp_r}) + (EXP_W+2)'(dist_r);

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SCAN;
      SCAN:    if (mant_is_zero || dist_calc == '0) next_state = DONE;
               else next_state = SHIFT;
      SHIFT:   if (remaining == DIST_W'(1)) next_state = DONE;
      DONE:    if (fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; the result registers load on the first DONE cycle
  always_comb begin
    in_ready    = (state == IDLE);
    load_result = (state == DONE) && !out_valid;
    state_dbg   = state;
  end

  // Working datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r    <= '0;
      exp_r     <= '0;
      sticky_r  <= 1'b0;
      zero_r    <= 1'b0;
      dist_r    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mant_r   <= mant_in;
            exp_r    <= exp_in;
            sticky_r <= 1'b0;
          end
        end
        SCAN: begin
          zero_r    <= mant_is_zero;
          dist_r    <= mant_is_zero ? '0 : dist_calc;
          remaining <= mant_is_zero ? '0 : dist_mag;
        end
        SHIFT: begin
          if (!dist_r[DIST_W-1]) begin
            mant_r   <= mant_r >> 1;
            sticky_r <= sticky_r | mant_r[0];
          end else begin
            mant_r <= mant_r << 1;
          end
          remaining <= remaining - DIST_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers; exponent saturates at both ends of the unsigned range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      distance  <= '0;
      sticky    <= 1'b0;
      zero      <= 1'b0;
      exp_uflow <= 1'b0;
      exp_oflow <= 1'b0;
    end else if (load_result) begin
      out_valid <= 1'b1;
      mant_out  <= mant_r;
      distance  <= dist_r;
      sticky    <= sticky_r;
      zero      <= zero_r;
      if (zero_r) begin
        exp_out   <= '0;
        exp_uflow <= 1'b0;
        exp_oflow <= 1'b0;
      end else if (exp_sum[EXP_W+1]) begin
        exp_out   <= '0;
        exp_uflow <= 1'b1;
        exp_oflow <= 1'b0;
      end else if (exp_sum[EXP_W]) begin
        exp_out   <= '1;
        exp_uflow <= 1'b0;
        exp_oflow <= 1'b1;
      end else begin
        exp_out   <= exp_sum[EXP_W-1:0];
        exp_uflow <= 1'b0;
        exp_oflow <= 1'b0;
      end
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
